demosaic_root_divq: RTL and testbench

- Sequential signed/unsigned divider: the inverse of the pipeline's signed-8 × unsigned-18 → signed-26 coefficient multiply.
- Takes a signed 26-bit product and its unsigned 18-bit scale, and recovers the signed 8-bit coefficient with remainder, saturation and divide-by-zero flags.
- Sits in the demosaic root datapath wherever a weighted sum must be normalised back to coefficient range.
- Iterative restoring algorithm: one quotient bit per cycle, valid/ready on both sides.

---
 rtl/demosaic_div_pkg.sv | 20 ++
 rtl/demosaic_div_sat.sv | 85 ++++++++
 rtl/demosaic_root_divq.sv | 144 ++++++++++++++
 tb/tb_demosaic_root_divq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_div_pkg.sv
// Shared types and constants for the demosaic root coefficient divider.
// Optional build macro: DEMOSAIC_DIV_ROUND_EN (round-to-nearest in FIX).
package demosaic_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DEF_DIVIDEND_W = 26;
    localparam int DEF_DIVISOR_W  = 18;
    localparam int DEF_QUOT_W     = 8;

    // Signed coefficient range the quotient is clamped to.
    localparam int QUOT_MAX = (1 << (DEF_QUOT_W - 1)) - 1;
    localparam int QUOT_MIN = -(1 << (DEF_QUOT_W - 1));

endpackage

// File: rtl/demosaic_div_sat.sv
// Combinational sign-apply / optional round / saturate stage used in FIX.
// Optional build macro: DEMOSAIC_DIV_ROUND_EN adds half-away-from-zero
// rounding of the magnitude before sign and saturation.
module demosaic_div_sat
    import demosaic_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                      neg_i,
    input  logic                      dbz_i,
    input  logic [DIVIDEND_W-1:0]     mag_i,
    input  logic [DIVISOR_W:0]        rem_i,
`ifdef DEMOSAIC_DIV_ROUND_EN
    input  logic [DIVISOR_W-1:0]      divisor_i,
`endif
    output logic signed [QUOT_W-1:0]  quot_o,
    output logic signed [DIVISOR_W:0] rem_o,
    output logic                      ovf_o
);

    // One extra bit so the rounding increment can never wrap.
    localparam int MW = DIVIDEND_W + 1;
    localparam logic [MW-1:0]     POS_LIM = MW'((1 << (QUOT_W - 1)) - 1);
    localparam logic [MW-1:0]     NEG_LIM = MW'(1 << (QUOT_W - 1));
    localparam logic [QUOT_W-1:0] Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};

`ifdef DEMOSAIC_DIV_ROUND_EN
    // Bump the magnitude when the discarded fraction is at least one half.
    function automatic logic [MW-1:0] round_mag(input logic [DIVIDEND_W-1:0] mag,
                                                input logic [DIVISOR_W:0]    rem,
                                                input logic [DIVISOR_W-1:0]  dvs);
        logic [DIVISOR_W+1:0] rem2;
        rem2 = {rem, 1'b0};
        if (rem2 >= {2'b00, dvs}) begin
            return {1'b0, mag} + MW'(1);
        end
        return {1'b0, mag};
    endfunction
`else
    function automatic logic [MW-1:0] round_mag(input logic [DIVIDEND_W-1:0] mag);
        return {1'b0, mag};
    endfunction
`endif

    // Returns {ovf, quotient}; a negative magnitude of exactly 2^(QUOT_W-1) is in range.
    function automatic logic [QUOT_W:0] sat_quot(input logic neg, input logic [MW-1:0] mag);
        logic [QUOT_W-1:0] low;
        low = mag[QUOT_W-1:0];
        if (!neg) begin
            if (mag > POS_LIM) begin
                return {1'b1, Q_MAX};
            end
            return {1'b0, low};
        end
        if (mag > NEG_LIM) begin
            return {1'b1, Q_MIN};
        end
        return {1'b0, -low};
    endfunction

    logic [MW-1:0]     mag_r;
    logic [QUOT_W:0]   sq;

    // Sign-apply and clamp; divide-by-zero overrides with a signed full-scale result.
    always_comb begin
`ifdef DEMOSAIC_DIV_ROUND_EN
        mag_r = round_mag(mag_i, rem_i, divisor_i);
`else
        mag_r = round_mag(mag_i);
`endif
        sq     = sat_quot(neg_i, mag_r);
        quot_o = $signed(sq[QUOT_W-1:0]);
        ovf_o  = sq[QUOT_W];
        rem_o  = neg_i ? -$signed(rem_i) : $signed(rem_i);
        if (dbz_i) begin
            quot_o = neg_i ? $signed(Q_MIN) : $signed(Q_MAX);
            ovf_o  = 1'b0;
            rem_o  = '0;
        end
    end

endmodule

// File: rtl/demosaic_root_divq.sv
// Iterative restoring divider recovering a signed coefficient from a
// signed product and its unsigned scale, one quotient bit per cycle.
// Optional build macro: DEMOSAIC_DIV_ROUND_EN (round-to-nearest in FIX).
module demosaic_root_divq
    import demosaic_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]         in_divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [QUOT_W-1:0]     out_quot,
    output logic signed [DIVISOR_W:0]    out_rem,
    output logic                         out_ovf,
    output logic                         out_dbz
);

    localparam int                CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

    div_state_e                  state_q;
    logic                        neg_q;
    logic                        dbz_q;
    // Holds the dividend magnitude at load; quotient bits shift in from the
    // bottom as magnitude bits shift out of the top.
    logic [DIVIDEND_W-1:0]       quo_q;
    logic [DIVISOR_W:0]          rem_q;
    logic [DIVISOR_W-1:0]        div_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic signed [QUOT_W-1:0]    out_quot_q;
    logic signed [DIVISOR_W:0]   out_rem_q;
    logic                        out_ovf_q;
    logic                        out_dbz_q;

    logic [DIVIDEND_W-1:0]       mag_d;
    logic [DIVISOR_W:0]          rem_sh;
    logic                        step_ge;
    logic [DIVISOR_W:0]          rem_d;
    logic [DIVIDEND_W-1:0]       quo_d;

    logic signed [QUOT_W-1:0]    fix_quot;
    logic signed [DIVISOR_W:0]   fix_rem;
    logic                        fix_ovf;

    // Operand magnitude and one restoring-division step.
    always_comb begin
        mag_d   = in_dividend[DIVIDEND_W-1] ? $unsigned(-in_dividend) : $unsigned(in_dividend);
        rem_sh  = {rem_q[DIVISOR_W-1:0], quo_q[DIVIDEND_W-1]};
        step_ge = (rem_sh >= {1'b0, div_q});
        rem_d   = step_ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
        quo_d   = {quo_q[DIVIDEND_W-2:0], step_ge};
    end

    demosaic_div_sat #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .QUOT_W     (QUOT_W)
    ) u_sat (
        .neg_i     (neg_q),
        .dbz_i     (dbz_q),
        .mag_i     (quo_q),
        .rem_i     (rem_q),
`ifdef DEMOSAIC_DIV_ROUND_EN
        .divisor_i (div_q),
`endif
        .quot_o    (fix_quot),
        .rem_o     (fix_rem),
        .ovf_o     (fix_ovf)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_quot_q  <= '0;
            out_rem_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        neg_q      <= in_dividend[DIVIDEND_W-1];
                        dbz_q      <= ~|in_divisor;
                        quo_q      <= mag_d;
                        div_q      <= in_divisor;
                        rem_q      <= '0;
                        cnt_q      <= CNT_LOAD;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    out_quot_q <= fix_quot;
                    out_rem_q  <= fix_rem;
                    out_ovf_q  <= fix_ovf;
                    out_dbz_q  <= dbz_q;
                    state_q    <= DONE;
                end
                DONE: begin
                    // Valid trails the result registers by one edge, so the
                    // data is already settled the first time it is seen.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_quot  = out_quot_q;
    assign out_rem   = out_rem_q;
    assign out_ovf   = out_ovf_q;
    assign out_dbz   = out_dbz_q;

endmodule

// File: tb/tb_demosaic_root_divq.sv
// Self-checking bench for demosaic_root_divq: directed corner cases, a
// backpressure hold, a mid-division reset and randomized operands, all
// compared against an arithmetic reference model.
module tb_demosaic_root_divq;
    import demosaic_div_pkg::*;

    localparam int DW  = 26;
    localparam int VW  = 18;
    localparam int QW  = 8;
    localparam int LAT = DW + 2;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_dividend = '0;
    logic [VW-1:0]        in_divisor = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [QW-1:0] out_quot;
    logic signed [VW:0]   out_rem;
    logic                 out_ovf;
    logic                 out_dbz;

    int n_vec = 0;
    int n_err = 0;

    longint dir_a [14] = '{-1200, 1000, -1280, -7, 5, 5, -5, -33554432,
                           0, 33554431, -1281, -1290, 254, 255};
    longint dir_b [14] = '{100, 7, 10, 2, 2, 0, 0, 1,
                           5, 262143, 10, 10, 2, 2};

    demosaic_root_divq dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_ovf     (out_ovf),
        .out_dbz     (out_dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer division truncates toward zero and % keeps the
    // dividend's sign, which is exactly the required quotient/remainder pair.
    task automatic ref_div(input longint a, input longint b,
                           output longint q, output longint r,
                           output longint ovf, output longint dbz);
        longint mag;
`ifdef DEMOSAIC_DIV_ROUND_EN
        longint rm;
`endif
        ovf = 0;
        dbz = 0;
        if (b == 0) begin
            dbz = 1;
            r   = 0;
            q   = (a < 0) ? QUOT_MIN : QUOT_MAX;
            return;
        end
        r   = a % b;
        mag = a / b;
        if (mag < 0) mag = -mag;
`ifdef DEMOSAIC_DIV_ROUND_EN
        rm = (r < 0) ? -r : r;
        if (2 * rm >= b) mag = mag + 1;
`endif
        q = (a < 0) ? -mag : mag;
        if (q > QUOT_MAX) begin
            q   = QUOT_MAX;
            ovf = 1;
        end else if (q < QUOT_MIN) begin
            q   = QUOT_MIN;
            ovf = 1;
        end
    endtask

    task automatic do_div(input longint a, input longint b, input string tag, input int hold);
        longint eq, er, eo, ed;
        int     lat;
        int     wt;
        ref_div(a, b, eq, er, eo, ed);
        wt = 0;
        while (!in_ready && wt < 100) begin
            @(posedge ap_clk); #1;
            wt++;
        end
        check($sformatf("%s ready", tag), longint'(in_ready), 1);
        in_dividend = DW'(a);
        in_divisor  = VW'(b);
        in_valid    = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        check($sformatf("%s busy", tag), longint'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 4 * LAT) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        check($sformatf("%s latency", tag), lat, LAT);
        check($sformatf("%s quot", tag), longint'(out_quot), eq);
        check($sformatf("%s rem", tag), longint'(out_rem), er);
        check($sformatf("%s ovf", tag), longint'(out_ovf), eo);
        check($sformatf("%s dbz", tag), longint'(out_dbz), ed);
        if (hold > 0) begin
            in_dividend = 26'sd999;
            in_divisor  = 18'd3;
            in_valid    = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk); #1;
            check($sformatf("%s hold%0d valid", tag, i), longint'(out_valid), 1);
            check($sformatf("%s hold%0d inrdy", tag, i), longint'(in_ready), 0);
            check($sformatf("%s hold%0d quot", tag, i), longint'(out_quot), eq);
            check($sformatf("%s hold%0d rem", tag, i), longint'(out_rem), er);
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check($sformatf("%s drain valid", tag), longint'(out_valid), 0);
        check($sformatf("%s drain inrdy", tag), longint'(in_ready), 1);
    endtask

    initial begin
        logic signed [DW-1:0] ra;
        longint               rb;
        logic                 seen;

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst in_ready", longint'(in_ready), 1);
        check("rst out_valid", longint'(out_valid), 0);
        check("rst out_quot", longint'(out_quot), 0);
        check("rst out_rem", longint'(out_rem), 0);
        check("rst out_ovf", longint'(out_ovf), 0);
        check("rst out_dbz", longint'(out_dbz), 0);
        ap_rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_div(dir_a[i], dir_b[i], $sformatf("dir%0d(%0d/%0d)", i, dir_a[i], dir_b[i]), 0);
        end

        do_div(-999, 37, "backpressure", 10);

        in_dividend = 26'sd1000;
        in_divisor  = 18'd3;
        in_valid    = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        check("midrst in_ready", longint'(in_ready), 1);
        check("midrst out_valid", longint'(out_valid), 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge ap_clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst no result", longint'(seen), 0);
        do_div(84, 4, "post-rst 84/4", 0);

        for (int i = 0; i < 30; i++) begin
            ra = DW'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 0;
                1, 2, 3: rb = longint'($urandom_range(1, 20));
                4, 5, 6: rb = longint'($urandom_range(1, 400000) % 262144);
                default: rb = longint'($urandom_range(100000, 262143));
            endcase
            if (i % 3 == 0 && rb != 0) begin
                ra = DW'(longint'($signed(QW'($urandom))) * rb + longint'($urandom_range(0, 3)));
            end
            do_div(longint'(ra), rb, $sformatf("rnd%0d(%0d/%0d)", i, longint'(ra), rb), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
